// File: rtl/fir_pin_pkg.sv
// Shared constants and FSM state type for the FIR tile pin driver.
// Widths match the tile's ui_in / uo_out / uio pin split.
package fir_pin_pkg;

  localparam int DATA_W     = 8;
  localparam int OUT_W      = 11;
  localparam int N_TAPS_DEF = 4;

  typedef enum logic [1:0] {
    IDLE,
    CFG,
    GUARD
  } state_t;

endpackage

// File: rtl/fir_valid_delay.sv
// LAT-deep valid shift register that tags samples in flight
// through the filter; flush drops everything in the pipe.
module fir_valid_delay #(
  parameter int LAT = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  input  logic din,
  output logic dout
);

  logic [LAT-1:0] sr;

  if (LAT == 1) begin : g_one
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sr <= '0;
      end else if (flush) begin
        sr <= '0;
      end else begin
        sr <= din;
      end
    end
  end else begin : g_many
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sr <= '0;
      end else if (flush) begin
        sr <= '0;
      end else begin
        sr <= {sr[LAT-2:0], din};
      end
    end
  end

  assign dout = sr[LAT-1];

endmodule

// File: rtl/fir_pin_driver.sv
// Host-side driver for the FIR tile pins: replays a shadow
// coefficient bank, streams samples and captures results.
module fir_pin_driver
  import fir_pin_pkg::*;
#(
  parameter int N_TAPS = N_TAPS_DEF,
  parameter int LAT    = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      coeff_wr,
  input  logic [$clog2(N_TAPS)-1:0] coeff_addr,
  input  logic [DATA_W-1:0]         coeff_data,
  input  logic                      cfg_start,
  input  logic                      smp_valid,
  input  logic [DATA_W-1:0]         smp_data,
  output logic                      smp_ready,
  output logic                      busy,
  output logic [DATA_W-1:0]         pin_ui,
  output logic                      pin_set_coeffs,
  output logic                      pin_tvalid,
  input  logic [OUT_W-1:0]          pin_y,
  output logic                      y_valid,
  output logic [OUT_W-1:0]          y_data
);

  localparam int AW = $clog2(N_TAPS);

  typedef logic [AW-1:0] idx_t;

  state_t            state;
  state_t            state_nx;
  idx_t              idx;
  idx_t              idx_nx;
  logic [DATA_W-1:0] bank [N_TAPS];
  logic [DATA_W-1:0] ui_nx;
  logic              set_nx;
  logic              tv_nx;
  logic              addr_ok;
  logic              wr_en;
  logic              enter_cfg;
  logic              tag;
  logic              cap;

  assign enter_cfg = (state == IDLE) && cfg_start;
  assign smp_ready = (state == IDLE) && !cfg_start;
  assign busy      = (state != IDLE);

  // Out-of-range addresses only exist for non power-of-two banks
  if (N_TAPS == (1 << AW)) begin : g_pow2
    assign addr_ok = 1'b1;
  end else begin : g_npow2
    assign addr_ok = coeff_addr < AW'(N_TAPS);
  end

  assign wr_en = (state == IDLE) && coeff_wr && addr_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_TAPS; i++) begin
        bank[i] <= '0;
      end
    end else if (wr_en) begin
      bank[coeff_addr] <= coeff_data;
    end
  end

  // Next pin values are decoded here and registered below
  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    ui_nx    = '0;
    set_nx   = 1'b0;
    tv_nx    = 1'b0;
    unique case (state)
      IDLE: begin
        if (cfg_start) begin
          state_nx = CFG;
          idx_nx   = '0;
          set_nx   = 1'b1;
          ui_nx    = bank[0];
        end else if (smp_valid) begin
          tv_nx = 1'b1;
          ui_nx = smp_data;
        end
      end
      CFG: begin
        if (idx == idx_t'(N_TAPS - 1)) begin
          state_nx = GUARD;
        end else begin
          idx_nx = idx + idx_t'(1);
          set_nx = 1'b1;
          ui_nx  = bank[idx_nx];
        end
      end
      GUARD: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      idx            <= '0;
      pin_ui         <= '0;
      pin_set_coeffs <= 1'b0;
      pin_tvalid     <= 1'b0;
    end else begin
      state          <= state_nx;
      idx            <= idx_nx;
      pin_ui         <= ui_nx;
      pin_set_coeffs <= set_nx;
      pin_tvalid     <= tv_nx;
    end
  end

  fir_valid_delay #(
    .LAT (LAT)
  ) u_tag (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (enter_cfg),
    .din   (pin_tvalid),
    .dout  (tag)
  );

  // A result landing on the cfg_start cycle is dropped as well
  assign cap = tag && !enter_cfg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_valid <= 1'b0;
      y_data  <= '0;
    end else begin
      y_valid <= cap;
      if (cap) begin
        y_data <= pin_y;
      end
    end
  end

endmodule

// File: tb/tb_fir_pin_driver.sv
// Bench: two drivers (LAT=1, LAT=4) in lockstep against a
// cycle model built from the pin protocol rules.
module tb_fir_pin_driver;
  import fir_pin_pkg::*;

  localparam int NT = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              coeff_wr = 1'b0;
  logic [1:0]        coeff_addr = '0;
  logic [DATA_W-1:0] coeff_data = '0;
  logic              cfg_start = 1'b0;
  logic              smp_valid = 1'b0;
  logic [DATA_W-1:0] smp_data = '0;

  logic              rdy [2];
  logic              bsy [2];
  logic [DATA_W-1:0] ui  [2];
  logic              set [2];
  logic              tv  [2];
  logic [OUT_W-1:0]  py  [2];
  logic              yv  [2];
  logic [OUT_W-1:0]  yd  [2];

  fir_pin_driver #(.N_TAPS(NT), .LAT(1)) u_a (
    .clk(clk), .rst_n(rst_n),
    .coeff_wr(coeff_wr), .coeff_addr(coeff_addr),
    .coeff_data(coeff_data), .cfg_start(cfg_start),
    .smp_valid(smp_valid), .smp_data(smp_data),
    .smp_ready(rdy[0]), .busy(bsy[0]),
    .pin_ui(ui[0]), .pin_set_coeffs(set[0]),
    .pin_tvalid(tv[0]), .pin_y(py[0]),
    .y_valid(yv[0]), .y_data(yd[0])
  );

  fir_pin_driver #(.N_TAPS(NT), .LAT(4)) u_b (
    .clk(clk), .rst_n(rst_n),
    .coeff_wr(coeff_wr), .coeff_addr(coeff_addr),
    .coeff_data(coeff_data), .cfg_start(cfg_start),
    .smp_valid(smp_valid), .smp_data(smp_data),
    .smp_ready(rdy[1]), .busy(bsy[1]),
    .pin_ui(ui[1]), .pin_set_coeffs(set[1]),
    .pin_tvalid(tv[1]), .pin_y(py[1]),
    .y_valid(yv[1]), .y_data(yd[1])
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;
  int cyc_no = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d",
               tag, cyc_no, got, exp);
    end
  endtask

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : 4;
  endfunction

  typedef struct {
    int             inst;
    int             due;
    logic [OUT_W-1:0] val;
  } res_t;

  // Model: bank contents, cycles left in the load sequence,
  // expected pins for the current cycle, pending results.
  logic [DATA_W-1:0] bank [NT];
  int                cfg_left;
  logic [DATA_W-1:0] e_ui;
  logic              e_set;
  logic              e_tv;
  res_t              pend [$];
  logic [OUT_W-1:0]  last [2];
  logic [DATA_W-1:0] hui [2][9];
  logic              htv [2][9];

  task automatic model_reset();
    for (int i = 0; i < NT; i++) bank[i] = '0;
    cfg_left = 0;
    e_ui = '0;
    e_set = 1'b0;
    e_tv = 1'b0;
    pend.delete();
    last[0] = '0;
    last[1] = '0;
  endtask

  task automatic step(input logic rst, input logic cs,
                      input logic sv, input logic [7:0] sd,
                      input logic wr, input logic [1:0] wa,
                      input logic [7:0] wd);
    logic idle;
    bit hit;
    logic [OUT_W-1:0] v;
    int j;
    rst_n = !rst;
    cfg_start = cs;
    smp_valid = sv;
    smp_data = sd;
    coeff_wr = wr;
    coeff_addr = wa;
    coeff_data = wd;
    if (rst) model_reset();
    #1;
    idle = (cfg_left == 0);
    for (int k = 0; k < 2; k++) begin
      chk("pin_ui", 32'(ui[k]), 32'(e_ui));
      chk("pin_set_coeffs", 32'(set[k]), 32'(e_set));
      chk("pin_tvalid", 32'(tv[k]), 32'(e_tv));
      chk("busy", 32'(bsy[k]), 32'(!idle));
      chk("smp_ready", 32'(rdy[k]), 32'(idle && !cs));
      hit = 0;
      v = last[k];
      j = 0;
      while (j < pend.size()) begin
        if (pend[j].inst == k && pend[j].due == cyc_no) begin
          hit = 1;
          v = pend[j].val;
          pend.delete(j);
        end else begin
          j++;
        end
      end
      chk("y_valid", 32'(yv[k]), 32'(hit));
      chk("y_data", 32'(yd[k]), 32'(v));
      last[k] = v;
      // Filter stand-in: y = 3*x, LAT cycles after tvalid
      for (int m = 8; m > 0; m--) begin
        hui[k][m] = hui[k][m-1];
        htv[k][m] = htv[k][m-1];
      end
      hui[k][0] = ui[k];
      htv[k][0] = tv[k];
      if (htv[k][lat_of(k)])
        py[k] = 11'(3 * int'(hui[k][lat_of(k)]));
      else
        py[k] = 11'($urandom);
    end
    if (!rst) begin
      if (idle && cs) begin
        cfg_left = NT + 1;
        e_set = 1'b1;
        e_ui = bank[0];
        e_tv = 1'b0;
        pend.delete();
      end else if (idle && sv) begin
        e_set = 1'b0;
        e_tv = 1'b1;
        e_ui = sd;
        for (int k = 0; k < 2; k++)
          pend.push_back('{k, cyc_no + lat_of(k) + 2,
                           11'(3 * int'(sd))});
      end else begin
        if (cfg_left > 0) cfg_left--;
        e_tv = 1'b0;
        e_set = (cfg_left >= 2);
        e_ui = (cfg_left >= 2) ? bank[NT + 1 - cfg_left] : '0;
      end
      if (idle && wr && int'(wa) < NT) bank[wa] = wd;
    end
    cyc_no++;
    @(negedge clk);
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    py[0] = '0;
    py[1] = '0;
    for (int k = 0; k < 2; k++)
      for (int m = 0; m < 9; m++) begin
        hui[k][m] = '0;
        htv[k][m] = 1'b0;
      end
    model_reset();
    #2 rst_n = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++)
      step(1, 1'($urandom), 1'($urandom), 8'($urandom),
           1'($urandom), 2'($urandom), 8'($urandom));
    idle_n(2);
    for (int i = 0; i < NT; i++)
      step(0, 0, 0, 0, 1, 2'(i), 8'(i + 1));
    step(0, 1, 0, 0, 0, 0, 0);
    idle_n(6);
    step(0, 0, 1, 8'd10, 0, 0, 0);
    step(0, 0, 1, 8'd20, 0, 0, 0);
    step(0, 0, 1, 8'd30, 0, 0, 0);
    idle_n(8);
    step(0, 1, 1, 8'd55, 0, 0, 0);
    idle_n(6);
    step(0, 0, 1, 8'd77, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 2'd0, 8'd99);
    step(0, 1, 0, 0, 1, 2'd1, 8'd98);
    idle_n(8);
    step(0, 1, 0, 0, 0, 0, 0);
    idle_n(7);
    step(0, 1, 0, 0, 0, 0, 0);
    idle_n(2);
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    idle_n(2);
    step(0, 1, 0, 0, 0, 0, 0);
    idle_n(7);
    for (int i = 0; i < 800; i++)
      step(($urandom % 200) == 0,
           ($urandom % 25) == 0,
           ($urandom % 3) != 0, 8'($urandom),
           ($urandom % 4) == 0, 2'($urandom), 8'($urandom));
    idle_n(8);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/fir_pin_driver.md
Name: fir_pin_driver

Overview:
- Host-side initiator for the FIR filter tile's pin interface.
- Holds a shadow coefficient bank and plays it into the filter during the coefficient-load phase (set_coeffs high).
- Streams samples into the filter's 8-bit data input, with tvalid asserted for each sample.
- Captures the 11-bit filter output (8 low bits on the dedicated outputs, 3 high bits on the bidirectional pins) and tags it with a valid strobe.
- Sits on the FPGA/test-harness side, facing the tile's ui_in / uio_in[7:6] / uo_out / uio_out[2:0].

Parameters:
- N_TAPS, 4, number of coefficients loaded per configuration.
- DATA_W, 8, sample and coefficient width.
- OUT_W, 11, filter output width.
- LAT, 1, cycles from pin_tvalid high to valid data on pin_y (range 1..8).

Ports:
- clk  in  1  system clock, single domain.
- rst_n  in  1  asynchronous, active-low reset.
- coeff_wr  in  1  write strobe for the shadow coefficient bank.
- coeff_addr  in  $clog2(N_TAPS)  coefficient index.
- coeff_data  in  DATA_W  coefficient value.
- cfg_start  in  1  single-cycle request to load the bank into the filter.
- smp_valid  in  1  host sample valid.
- smp_data  in  DATA_W  host sample.
- smp_ready  out  1  sample accepted when smp_valid && smp_ready.
- busy  out  1  configuration sequence in progress.
- pin_ui  out  DATA_W  drives the filter's ui_in.
- pin_set_coeffs  out  1  drives the filter's uio_in[6].
- pin_tvalid  out  1  drives the filter's uio_in[7].
- pin_y  in  OUT_W  {uio_out[2:0], uo_out[7:0]} from the filter.
- y_valid  out  1  captured output valid.
- y_data  out  OUT_W  captured output, passed bit-exact with no sign handling.

Behaviour:
- Reset (async assert, sync deassert is the integrator's responsibility):
  - pin_ui, pin_set_coeffs, pin_tvalid, y_valid, y_data, busy = 0.
  - Coefficient bank cleared to 0; state = IDLE; tag pipeline cleared.
- All pin_* outputs and y_* outputs are registered. smp_ready is combinational: (state==IDLE) && !cfg_start.
- FSM states and transitions:
  - IDLE: accept samples; cfg_start=1 -> CFG with idx=0.
  - CFG: pin_set_coeffs=1, pin_ui=coeff[idx], pin_tvalid=0; idx increments each cycle; after idx=N_TAPS-1 -> GUARD.
  - GUARD: one cycle with pin_set_coeffs=0, pin_tvalid=0, pin_ui=0; then -> IDLE.
  - busy=1 in CFG and GUARD.
- CFG timing: pin_set_coeffs is high for exactly N_TAPS consecutive cycles, starting the cycle after cfg_start.
- Sample path: on an accepted sample, the next cycle has pin_ui=smp_data and pin_tvalid=1. Back-to-back accepts give continuous tvalid. With no accept, pin_tvalid=0 and pin_ui=0.
- Capture path:
  - The tag shift register (depth LAT) carries pin_tvalid.
  - When the tag output is 1, pin_y is registered into y_data and y_valid=1 on the next cycle.
  - If the first tvalid cycle is t0, y_valid is high at t0+LAT+1. Throughput is one result per cycle.
  - When the tag is 0, y_valid=0 and y_data holds its last value.
- Boundary conditions:
  - cfg_start and smp_valid in the same IDLE cycle: configuration wins and the sample is not accepted.
  - Entering CFG flushes the tag pipeline. Results of in-flight samples are dropped, so no y_valid occurs during CFG or GUARD.
  - cfg_start while busy: ignored.
  - coeff_wr while busy: ignored, so the bank stays stable during the load.
  - coeff_wr in IDLE: the write takes effect next cycle.
  - coeff_addr >= N_TAPS: the write is ignored. This applies when N_TAPS is not a power of two.
  - Reset mid-CFG: pin_set_coeffs drops immediately; after release the state is IDLE. The filter's partially loaded coefficients are the host's responsibility to reload.

Decomposition:
- Package fir_pin_pkg holds:
  - DATA_W, OUT_W and the default N_TAPS constants.
  - The state enum {IDLE, CFG, GUARD}.
- One sub-module, fir_valid_delay: a parameterised LAT-deep valid shift register with synchronous flush and async active-low reset.

Test Plan:
- Reset: hold rst_n=0 with random inputs -> all outputs 0 and smp_ready=1 after release.
- Configuration load: write coeffs 1,2,3,4 to addresses 0..3, then pulse cfg_start -> pin_set_coeffs high for 4 cycles with pin_ui=1,2,3,4, one guard cycle at 0, busy high for 5 cycles.
- Streaming: feed samples 10,20,30 back-to-back with a pin_y model of y = 3*x (LAT=1) -> pin_tvalid high for 3 cycles; y_valid high 2 cycles after each tvalid cycle with y_data=30,60,90.
- Collision: cfg_start and smp_valid=1 (data 55) in the same cycle -> smp_ready=0, no tvalid carrying 55, CFG starts the next cycle.
- Flush and write protection: start a sample at LAT=4, then cfg_start 1 cycle later -> no y_valid is ever emitted for that sample. coeff_wr to address 0 during CFG -> the next configuration still replays the old value.
- Reset mid-CFG: assert rst_n=0 at idx=2 -> pin_set_coeffs=0 immediately, the bank reads back 0 on the next configuration, state is IDLE.
